// File: rtl/proc_control_unit.sv
// Fetch/execute step sequencer and instruction decoder for the 16-bit processor datapath.
// Optional build macro PROC_CTRL_ILLEGAL_TRAP_EN: opcode 111 traps into HALT instead of executing as a NOP.
module proc_control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] IR,
  output logic [2:0]  Tstep_Q,
  output logic [7:0]  R_in,
  output logic [7:0]  R_out,
  output logic        Imm_out,
  output logic        Imm_hi,
  output logic        Din_out,
  output logic        G_out,
  output logic        IR_in,
  output logic        A_in,
  output logic        G_in,
  output logic        ADDR_in,
  output logic        DOUT_in,
  output logic        W_D,
  output logic        pc_incr,
  output logic [1:0]  Select,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned NREG  = 8;
  localparam int unsigned REG_W = 3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_E3   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       op;
  logic             imm;
  logic [REG_W-1:0] rx, ry;
  logic [NREG-1:0]  rx_oh, ry_oh;
  logic [1:0]       alu_sel;
  logic             unused_ir;

  assign op        = IR[15:13];
  assign imm       = IR[12];
  assign rx        = IR[11:9];
  assign ry        = IR[2:0];
  assign rx_oh     = NREG'(1) << rx;
  assign ry_oh     = NREG'(1) << ry;
  // Immediate payload bits are consumed by the datapath, not by the decoder.
  assign unused_ir = ^IR[8:3];

  always_comb begin
    case (op)
      OP_SUB:  alu_sel = 2'b01;
      OP_AND:  alu_sel = 2'b10;
      default: alu_sel = 2'b00;
    endcase
  end

  assign Tstep_Q = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Moore decode of strobes and next step from the step register and IR.
  always_comb begin
    state_nxt = state;
    R_in      = '0;
    R_out     = '0;
    Imm_out   = 1'b0;
    Imm_hi    = 1'b0;
    Din_out   = 1'b0;
    G_out     = 1'b0;
    IR_in     = 1'b0;
    A_in      = 1'b0;
    G_in      = 1'b0;
    ADDR_in   = 1'b0;
    DOUT_in   = 1'b0;
    W_D       = 1'b0;
    pc_incr   = 1'b0;
    Select    = 2'b00;
    done      = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: if (run) state_nxt = S_F0;
      S_F0: begin
        R_out[NREG-1] = 1'b1;
        ADDR_in       = 1'b1;
        pc_incr       = 1'b1;
        state_nxt     = S_F1;
      end
      S_F1: state_nxt = S_F2;
      S_F2: begin
        Din_out   = 1'b1;
        IR_in     = 1'b1;
        state_nxt = S_E1;
      end
      S_E1: begin
        case (op)
          OP_MV: begin
            if (imm) Imm_out = 1'b1;
            else     R_out   = ry_oh;
            R_in = rx_oh;
            done = 1'b1;
          end
          OP_MVT: begin
            Imm_out = 1'b1;
            Imm_hi  = 1'b1;
            R_in    = rx_oh;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            R_out     = rx_oh;
            A_in      = 1'b1;
            state_nxt = S_E2;
          end
          OP_LD, OP_ST: begin
            R_out     = ry_oh;
            ADDR_in   = 1'b1;
            state_nxt = S_E2;
          end
          default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
`else
            done = 1'b1;
`endif
          end
        endcase
      end
      S_E2: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            if (imm) Imm_out = 1'b1;
            else     R_out   = ry_oh;
            G_in      = 1'b1;
            Select    = alu_sel;
            state_nxt = S_E3;
          end
          OP_LD: state_nxt = S_E3;
          OP_ST: begin
            R_out   = rx_oh;
            DOUT_in = 1'b1;
            W_D     = 1'b1;
            done    = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_E3: begin
        case (op)
          OP_LD: begin
            Din_out = 1'b1;
            R_in    = rx_oh;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            G_out = 1'b1;
            R_in  = rx_oh;
            done  = 1'b1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_HALT: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        illegal   = 1'b1;
        state_nxt = S_HALT;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase

    // Instruction completion: continue straight into the next fetch if run is held.
    if (done) state_nxt = run ? S_F0 : S_IDLE;
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: expected per-step strobe vectors are queued with
// the stimulus to apply, then popped and compared once per cycle on the falling edge.
module tb_proc_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic [15:0] IR    = '0;
  logic [2:0]  Tstep_Q;
  logic [7:0]  R_in, R_out;
  logic        Imm_out, Imm_hi, Din_out, G_out, IR_in, A_in, G_in;
  logic        ADDR_in, DOUT_in, W_D, pc_incr, done, illegal;
  logic [1:0]  Select;

  always #5 clock = ~clock;

  proc_control_unit dut (
    .clock(clock), .reset(reset), .run(run), .IR(IR), .Tstep_Q(Tstep_Q),
    .R_in(R_in), .R_out(R_out), .Imm_out(Imm_out), .Imm_hi(Imm_hi),
    .Din_out(Din_out), .G_out(G_out), .IR_in(IR_in), .A_in(A_in), .G_in(G_in),
    .ADDR_in(ADDR_in), .DOUT_in(DOUT_in), .W_D(W_D), .pc_incr(pc_incr),
    .Select(Select), .done(done), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] t;
    logic [7:0] rin;
    logic [7:0] rout;
    logic imm, immhi, din, gout, irin, ain, gin, addr, dout, wd, pci;
    logic [1:0] sel;
    logic done;
    logic ill;
  } ctl_t;

  typedef struct packed {
    ctl_t        exp;
    logic        drun;
    logic [15:0] dir;
  } entry_t;

  ctl_t   act;
  entry_t sbq[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  assign act = {Tstep_Q, R_in, R_out, Imm_out, Imm_hi, Din_out, G_out, IR_in, A_in,
                G_in, ADDR_in, DOUT_in, W_D, pc_incr, Select, done, illegal};

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic ctl_t with_operand(input ctl_t c, input logic [15:0] ir);
    ctl_t r;
    r = c;
    if (ir[12]) r.imm = 1'b1;
    else        r.rout = oh(ir[2:0]);
    return r;
  endfunction

  task automatic push(input ctl_t c, input logic r, input logic [15:0] ir);
    entry_t e;
    e.exp  = c;
    e.drun = r;
    e.dir  = ir;
    sbq.push_back(e);
  endtask

  // Expected step sequence from F0 through the done step of one instruction.
  task automatic push_instr(input logic [15:0] ir, input logic next_run);
    ctl_t       c;
    logic [2:0] op;
    logic [7:0] rx, ry;
    op = ir[15:13];
    rx = oh(ir[11:9]);
    ry = oh(ir[2:0]);
    c = '0; c.t = 3'd1; c.rout = 8'h80; c.addr = 1'b1; c.pci = 1'b1; push(c, 1'b0, ir);
    c = '0; c.t = 3'd2; push(c, 1'b0, ir);
    c = '0; c.t = 3'd3; c.din = 1'b1; c.irin = 1'b1; push(c, 1'b0, ir);
    c = '0; c.t = 3'd4;
    case (op)
      3'b000: begin
        c = with_operand(c, ir); c.rin = rx; c.done = 1'b1; push(c, 1'b0, ir);
      end
      3'b001: begin
        c.imm = 1'b1; c.immhi = 1'b1; c.rin = rx; c.done = 1'b1; push(c, 1'b0, ir);
      end
      3'b010, 3'b011, 3'b110: begin
        c.rout = rx; c.ain = 1'b1; push(c, 1'b0, ir);
        c = '0; c.t = 3'd5; c = with_operand(c, ir); c.gin = 1'b1;
        c.sel = (op == 3'b011) ? 2'b01 : (op == 3'b110) ? 2'b10 : 2'b00;
        push(c, 1'b0, ir);
        c = '0; c.t = 3'd6; c.gout = 1'b1; c.rin = rx; c.done = 1'b1; push(c, 1'b0, ir);
      end
      3'b100: begin
        c.rout = ry; c.addr = 1'b1; push(c, 1'b0, ir);
        c = '0; c.t = 3'd5; push(c, 1'b0, ir);
        c = '0; c.t = 3'd6; c.din = 1'b1; c.rin = rx; c.done = 1'b1; push(c, 1'b0, ir);
      end
      3'b101: begin
        c.rout = ry; c.addr = 1'b1; push(c, 1'b0, ir);
        c = '0; c.t = 3'd5; c.rout = rx; c.dout = 1'b1; c.wd = 1'b1; c.done = 1'b1;
        push(c, 1'b0, ir);
      end
      default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        push(c, 1'b1, ir);
        for (int k = 0; k < 4; k++) begin
          c = '0; c.t = 3'd7; c.ill = 1'b1; push(c, 1'b1, ir);
        end
`else
        c.done = 1'b1; push(c, 1'b0, ir);
`endif
      end
    endcase
    sbq[sbq.size()-1].drun = next_run;
  endtask

  // Scoreboard consumer: compare the current step, then apply the inputs for the next edge.
  task automatic drain(input string name);
    entry_t e;
    int     step;
    step = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clock);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s step %0d: actual %h expected %h", name, step, act, e.exp);
      end
      run = e.drun;
      IR  = e.dir;
      step++;
    end
  endtask

  task automatic single(input string name, input logic [15:0] ir);
    push('0, 1'b1, ir);
    push_instr(ir, 1'b0);
    push('0, 1'b0, ir);
    drain(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (act !== ctl_t'('0)) begin
      n_fail++;
      $display("FAIL reset_held: actual %h expected %h", act, ctl_t'('0));
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) push('0, 1'b0, 16'h0000);
    drain("reset_idle");
  endtask

  task automatic test_mv();
    single("mv_imm", 16'h1004);
    single("mv_jump_reg", 16'h0E02);
    single("mvt", 16'h38AA);
  endtask

  task automatic test_alu();
    single("add_imm", 16'h5209);
    single("sub_reg", 16'h6403);
    single("and_imm", 16'hD605);
  endtask

  task automatic test_mem();
    single("ld", 16'h8200);
    single("st", 16'hA001);
  endtask

  task automatic test_back_to_back();
    push('0, 1'b1, 16'h5209);
    push_instr(16'h5209, 1'b1);
    push_instr(16'hA001, 1'b1);
    push_instr(16'h38AA, 1'b0);
    push('0, 1'b0, 16'h38AA);
    drain("back_to_back");
  endtask

  task automatic test_reserved();
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    push('0, 1'b1, 16'hE000);
    push_instr(16'hE000, 1'b1);
    drain("halt");
    reset = 1'b0;
    #1;
    n_checks++;
    if (act !== ctl_t'('0)) begin
      n_fail++;
      $display("FAIL halt_reset_exit: actual %h expected %h", act, ctl_t'('0));
    end
    run = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    push('0, 1'b0, 16'hE000);
    push('0, 1'b0, 16'hE000);
    drain("after_halt");
`else
    single("nop_111", 16'hE000);
`endif
  endtask

  task automatic test_reset_abort();
    ctl_t c;
    push('0, 1'b1, 16'h5209);
    push_instr(16'h5209, 1'b0);
    void'(sbq.pop_back());
    drain("abort_pre");
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (act !== ctl_t'('0)) begin
      n_fail++;
      $display("FAIL abort_immediate: actual %h expected %h", act, ctl_t'('0));
    end
    @(posedge clock);
    #1;
    c = act;
    n_checks++;
    if (c.rin !== 8'h00 || c.t !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_next_edge: actual %h expected %h", c, ctl_t'('0));
    end
    @(negedge clock);
    reset = 1'b1;
    push('0, 1'b0, 16'h5209);
    push('0, 1'b0, 16'h5209);
    drain("after_abort");
  endtask

  initial begin
    test_reset();
    test_mv();
    test_alu();
    test_mem();
    test_back_to_back();
    test_reserved();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
